// File: rtl/bsg_dff_reset_en_pipe.sv
// depth_p-stage valid/ready register pipeline with bubble collapse, flush and occupancy count.
// Define BSG_DFF_RESET_EN_PIPE_DATA_RESET_EN to also reset the data registers to reset_val_p.
module bsg_dff_reset_en_pipe #(
  parameter int                 width_p     = 16,
  parameter int                 depth_p     = 3,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         flush_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         ready_and_i,
  output logic [$clog2(depth_p+1)-1:0] count_o
);

  localparam int cnt_w_lp = $clog2(depth_p + 1);

  if (depth_p < 1) begin : g_bad_depth
    $error("bsg_dff_reset_en_pipe: depth_p must be >= 1");
  end
  if (width_p < 1) begin : g_bad_width
    $error("bsg_dff_reset_en_pipe: width_p must be >= 1");
  end

  logic [depth_p-1:0]  valid_q, valid_d, adv, src_v, data_en;
  logic [width_p-1:0]  data_q   [depth_p];
  logic [width_p-1:0]  data_src [depth_p];
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                in_fire, out_fire;

  // A stage advances when it is empty or everything ahead of it advances,
  // so empty slots are always filled even while the head is stalled.
  always_comb begin : adv_chain
    logic carry;
    carry = ready_and_i;
    for (int k = depth_p - 1; k >= 0; k--) begin
      carry  = ~valid_q[k] | carry;
      adv[k] = carry;
    end
  end

  assign ready_o  = adv[0] & ~flush_i;
  assign in_fire  = v_i & ready_o;
  assign out_fire = valid_q[depth_p-1] & ready_and_i & ~flush_i;

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    src_v[0]    = in_fire;
    data_src[0] = data_i;
    for (int k = 1; k < depth_p; k++) begin
      src_v[k]    = valid_q[k-1];
      data_src[k] = data_q[k-1];
    end
    data_en = adv & {depth_p{~flush_i}};
    valid_d = flush_i ? '0 : ((adv & src_v) | (~adv & valid_q));
  end

  always_comb begin
    count_d = count_q;
    if (flush_i)                 count_d = '0;
    else if (in_fire & ~out_fire) count_d = count_q + cnt_w_lp'(1);
    else if (out_fire & ~in_fire) count_d = count_q - cnt_w_lp'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

`ifdef BSG_DFF_RESET_EN_PIPE_DATA_RESET_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < depth_p; k++) data_q[k] <= reset_val_p;
    end else begin
      for (int k = 0; k < depth_p; k++)
        if (data_en[k]) data_q[k] <= data_src[k];
    end
  end
`else
  // NOTE: data flops deliberately have no reset; the valid bits alone say
  // whether their contents mean anything.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < depth_p; k++)
      if (data_en[k]) data_q[k] <= data_src[k];
  end
`endif

  assign v_o     = valid_q[depth_p-1];
  assign data_o  = data_q[depth_p-1];
  assign count_o = count_q;

endmodule

// File: tb/tb_bsg_dff_reset_en_pipe.sv
// Self-checking bench for bsg_dff_reset_en_pipe: directed scenarios plus random
// stress against a queue model that tracks each item's stage position.
module tb_bsg_dff_reset_en_pipe;

  localparam int         W     = 16;
  localparam int         DEPTH = 3;
  localparam logic [W-1:0] RVAL = 16'h5A5A;

  logic         clk = 1'b0;
  logic         reset_n_i, flush_i, v_i, ready_and_i;
  logic [W-1:0] data_i;
  logic         ready_o, v_o;
  logic [W-1:0] data_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  bsg_dff_reset_en_pipe #(.width_p(W), .depth_p(DEPTH), .reset_val_p(RVAL)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .flush_i(flush_i), .v_i(v_i),
    .data_i(data_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o),
    .ready_and_i(ready_and_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] data; int pos; } item_t;
  item_t q[$];   // oldest first; pos = stage index, DEPTH-1 is the head

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, check outputs against the model, then advance the model.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic rdy, input logic fl);
    logic  exp_ready, exp_v;
    int    lim;
    item_t it;
    v_i = v; data_i = d; ready_and_i = rdy; flush_i = fl;
    #1;
    exp_ready = ((q.size() < DEPTH) || rdy) && !fl;
    exp_v     = (q.size() > 0) && (q[0].pos == DEPTH - 1);
    check("ready_o", 32'(ready_o), 32'(exp_ready));
    check("v_o",     32'(v_o),     32'(exp_v));
    check("count_o", 32'(count_o), q.size());
    if (exp_v) check("data_o", 32'(data_o), 32'(q[0].data));
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (exp_v && rdy) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        lim = (i == 0) ? DEPTH - 1 : q[i-1].pos - 1;
        if (q[i].pos + 1 <= lim) q[i].pos = q[i].pos + 1;
      end
      if (v && exp_ready) begin
        it.data = d; it.pos = 0;
        q.push_back(it);
      end
    end
    #1;
  endtask

  initial begin
    reset_n_i = 1'b0; flush_i = 1'b0; v_i = 1'b0; ready_and_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_v_o", 32'(v_o), 0);
    check("rst_count", 32'(count_o), 0);
`ifdef BSG_DFF_RESET_EN_PIPE_DATA_RESET_EN
    check("rst_data", 32'(data_o), 32'(RVAL));
`endif
    reset_n_i = 1'b1;

    // Stream 1,2,3 with an always-ready consumer.
    for (int i = 1; i <= 3; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    check("stream_count_peak", 32'(count_o), 3);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure: four pushes into a stalled pipe.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'hA000 + W'(i), 1'b0, 1'b0);
    check("bp_count", 32'(count_o), 3);
    check("bp_ready", 32'(ready_o), 0);
    check("bp_head",  32'(data_o), 32'h0000A000);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Bubble collapse behind a stalled head.
    cycle(1'b1, 16'h1111, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("bub_count", 32'(count_o), 2);
    check("bub_head",  32'(data_o), 32'h00001111);
    check("bub_ready", 32'(ready_o), 1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush with concurrent input and output requests.
    cycle(1'b1, 16'hC001, 1'b0, 1'b0);
    cycle(1'b1, 16'hC002, 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b1);
    check("flush_count", 32'(count_o), 0);
    check("flush_v_o",   32'(v_o), 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges with two items in flight.
    cycle(1'b1, 16'hD001, 1'b0, 1'b0);
    cycle(1'b1, 16'hD002, 1'b0, 1'b0);
    v_i = 1'b0;
    check("pre_arst_count", 32'(count_o), 2);
    #1 reset_n_i = 1'b0;
    #1;
    check("arst_v_o",   32'(v_o), 0);
    check("arst_count", 32'(count_o), 0);
`ifdef BSG_DFF_RESET_EN_PIPE_DATA_RESET_EN
    check("arst_data", 32'(data_o), 32'(RVAL));
`endif
    q.delete();
    @(posedge clk);
    #1 reset_n_i = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Random stress.
    for (int n = 0; n < 10000; n++)
      cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 99) < 2));
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
